// File: rtl/logic_repeat_pkg.sv
// Shared types and default widths for the repeat sequencer.
package logic_repeat_pkg;

   localparam int unsigned DEF_CNT_W  = 16;
   localparam int unsigned DEF_TIME_W = 24;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_GAP  = 2'd2
   } rpt_state_e;

endpackage

// File: rtl/logic_repeat_seq_if.sv
// Control/status bundle between a sequence owner (master) and the repeat sequencer (slave).
interface logic_repeat_seq_if
   import logic_repeat_pkg::*;
#(
   parameter int CNT_W  = DEF_CNT_W,
   parameter int TIME_W = DEF_TIME_W
);

   logic              io_mainTrigger;
   logic [CNT_W-1:0]  io_rptNo;
   logic [TIME_W-1:0] io_rptTime;
   logic              io_infinite;
   logic              io_abort;
   logic              io_logicEnd;
   logic              io_rptEn;
   logic              io_logicBusy;
   logic [CNT_W-1:0]  io_rptCnt;
   logic              io_done;
   logic              io_aborted;

   modport master (
      output io_mainTrigger, io_rptNo, io_rptTime, io_infinite, io_abort, io_logicEnd,
      input  io_rptEn, io_logicBusy, io_rptCnt, io_done, io_aborted
   );

   modport slave (
      input  io_mainTrigger, io_rptNo, io_rptTime, io_infinite, io_abort, io_logicEnd,
      output io_rptEn, io_logicBusy, io_rptCnt, io_done, io_aborted
   );

endinterface

// File: rtl/rpt_gap_timer.sv
// Inter-pass gap timer: clears on load, counts while enabled, flags the last gap cycle.
module rpt_gap_timer #(
   parameter int TIME_W = 24
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              en_i,
   input  logic [TIME_W-1:0] time_i,
   output logic              tc_o
);

   logic [TIME_W-1:0] cnt_q, cnt_d;
   logic [TIME_W-1:0] term;

   // A zero gap behaves as one cycle, so the terminal value never underflows.
   always_comb begin
      if (time_i == '0) term = '0;
      else              term = time_i - TIME_W'(1);
   end

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)    cnt_d = '0;
      else if (en_i) cnt_d = cnt_q + TIME_W'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign tc_o = en_i && (cnt_q == term);

endmodule

// File: rtl/logic_repeat_seq.sv
// Repeat sequencer: runs a logic engine for 1+rptNo passes (or forever) with a timed gap between passes.
module logic_repeat_seq
   import logic_repeat_pkg::*;
#(
   parameter int CNT_W  = DEF_CNT_W,
   parameter int TIME_W = DEF_TIME_W
) (
   input  logic               io_clk,
   input  logic               io_rst,
   logic_repeat_seq_if.slave  bus
);

   rpt_state_e        state_q, state_d;
   logic [CNT_W-1:0]  rpt_no_q, rpt_no_d;
   logic [TIME_W-1:0] rpt_time_q, rpt_time_d;
   logic              inf_q, inf_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              abt_q, abt_d;

   logic              gap_load, gap_en, gap_tc;
   logic              rpt_en;

   rpt_gap_timer #(
      .TIME_W (TIME_W)
   ) u_gap (
      .clk_i  (io_clk),
      .rst_i  (io_rst),
      .load_i (gap_load),
      .en_i   (gap_en),
      .time_i (rpt_time_q),
      .tc_o   (gap_tc)
   );

   assign gap_en = (state_q == ST_GAP);

   always_comb begin
      state_d    = state_q;
      rpt_no_d   = rpt_no_q;
      rpt_time_d = rpt_time_q;
      inf_d      = inf_q;
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      abt_d      = 1'b0;
      gap_load   = 1'b0;
      rpt_en     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.io_mainTrigger) begin
               rpt_no_d   = bus.io_rptNo;
               rpt_time_d = bus.io_rptTime;
               inf_d      = bus.io_infinite;
               cnt_d      = '0;
               gap_load   = 1'b1;
               busy_d     = 1'b1;
               state_d    = ST_RUN;
            end
         end
         ST_RUN: begin
            // Abort takes priority over a pass ending in the same cycle.
            if (bus.io_abort) begin
               abt_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (bus.io_logicEnd) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (inf_q || (cnt_q < rpt_no_q)) begin
                  gap_load = 1'b1;
                  state_d  = ST_GAP;
               end else begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (bus.io_abort) begin
               abt_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (gap_tc) begin
               rpt_en  = 1'b1;
               state_d = ST_RUN;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge io_clk or posedge io_rst) begin
      if (io_rst) begin
         state_q    <= ST_IDLE;
         rpt_no_q   <= '0;
         rpt_time_q <= '0;
         inf_q      <= 1'b0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         abt_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rpt_no_q   <= rpt_no_d;
         rpt_time_q <= rpt_time_d;
         inf_q      <= inf_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         abt_q      <= abt_d;
      end
   end

   assign bus.io_rptEn     = rpt_en;
   assign bus.io_logicBusy = busy_q;
   assign bus.io_rptCnt    = cnt_q;
   assign bus.io_done      = done_q;
   assign bus.io_aborted   = abt_q;

endmodule

// File: tb/tb_logic_repeat_seq.sv
// Directed bench for logic_repeat_seq: pass counting, gap timing, wrap, abort and reset behaviour.
module tb_logic_repeat_seq;
   import logic_repeat_pkg::*;

   localparam int CW = 4;
   localparam int TW = 8;

   logic io_clk = 1'b0;
   logic io_rst = 1'b1;
   always #5 io_clk = ~io_clk;

   logic_repeat_seq_if #(.CNT_W(CW), .TIME_W(TW)) bus ();

   logic_repeat_seq #(
      .CNT_W  (CW),
      .TIME_W (TW)
   ) dut (
      .io_clk (io_clk),
      .io_rst (io_rst),
      .bus    (bus)
   );

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   end_cyc = 0;
   int   en_cyc  = 0;
   int   n_en    = 0;
   int   n_done  = 0;
   int   n_ab    = 0;
   logic en_now, done_now, ab_now;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Samples one cycle mid-period, then advances to just after the next rising edge.
   task automatic tick();
      @(negedge io_clk);
      en_now   = bus.io_rptEn;
      done_now = bus.io_done;
      ab_now   = bus.io_aborted;
      if (en_now) begin
         n_en++;
         en_cyc = cyc;
      end
      if (done_now) n_done++;
      if (ab_now)   n_ab++;
      @(posedge io_clk);
      cyc++;
      #1;
   endtask

   task automatic clr_counts();
      n_en = 0; n_done = 0; n_ab = 0;
   endtask

   task automatic pulse_end();
      bus.io_logicEnd = 1'b1;
      end_cyc = cyc;
      tick();
      bus.io_logicEnd = 1'b0;
   endtask

   task automatic trigger(input logic [CW-1:0] no, input logic [TW-1:0] tm, input logic inf);
      bus.io_rptNo       = no;
      bus.io_rptTime     = tm;
      bus.io_infinite    = inf;
      bus.io_mainTrigger = 1'b1;
      tick();
      bus.io_mainTrigger = 1'b0;
   endtask

   task automatic wait_en(input string tag, input int exp_gap);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         tick();
         got = en_now;
      end
      chk({tag, "_seen"}, 32'(got), 1);
      if (got) chk({tag, "_gap"}, en_cyc - end_cyc, exp_gap);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.io_mainTrigger = 1'b0;
      bus.io_rptNo       = '0;
      bus.io_rptTime     = '0;
      bus.io_infinite    = 1'b0;
      bus.io_abort       = 1'b0;
      bus.io_logicEnd    = 1'b0;
      repeat (3) @(posedge io_clk);
      #1;
      chk("rst_busy",  32'(bus.io_logicBusy), 0);
      chk("rst_cnt",   32'(bus.io_rptCnt), 0);
      chk("rst_en",    32'(bus.io_rptEn), 0);
      chk("rst_done",  32'(bus.io_done), 0);
      chk("rst_abort", 32'(bus.io_aborted), 0);
      io_rst = 1'b0;

      // rptNo=2, rptTime=5: three passes, gap of 5 cycles each; trigger right after reset release
      clr_counts();
      trigger(4'd2, 8'd5, 1'b0);
      chk("s1_busy", 32'(bus.io_logicBusy), 1);
      for (int p = 0; p < 3; p++) begin
         repeat (2) tick();
         pulse_end();
         if (p < 2) wait_en("s1_en", 5);
      end
      tick();
      chk("s1_done",   32'(done_now), 1);
      chk("s1_cnt",    32'(bus.io_rptCnt), 3);
      chk("s1_busy0",  32'(bus.io_logicBusy), 0);
      chk("s1_nen",    n_en, 2);
      chk("s1_ndone",  n_done, 1);

      // rptNo=0, rptTime=0: single pass
      clr_counts();
      trigger(4'd0, 8'd0, 1'b0);
      tick();
      pulse_end();
      tick();
      chk("s2a_done", 32'(done_now), 1);
      chk("s2a_nen",  n_en, 0);
      chk("s2a_cnt",  32'(bus.io_rptCnt), 1);

      // rptNo=1, rptTime=0: gap treated as one cycle
      clr_counts();
      trigger(4'd1, 8'd0, 1'b0);
      tick();
      pulse_end();
      tick();
      chk("s2b_en",   32'(en_now), 1);
      chk("s2b_gap",  en_cyc - end_cyc, 1);
      pulse_end();
      tick();
      chk("s2b_done", 32'(done_now), 1);
      chk("s2b_cnt",  32'(bus.io_rptCnt), 2);
      chk("s2b_nen",  n_en, 1);

      // infinite, rptTime=1: 20 passes, counter wraps 15 -> 0
      clr_counts();
      trigger(4'd0, 8'd1, 1'b1);
      for (int p = 1; p <= 20; p++) begin
         tick();
         pulse_end();
         if (p == 15) chk("s3_cnt15", 32'(bus.io_rptCnt), 15);
         if (p == 16) chk("s3_wrap",  32'(bus.io_rptCnt), 0);
         tick();
      end
      chk("s3_nen",   n_en, 20);
      chk("s3_ndone", n_done, 0);
      chk("s3_cnt",   32'(bus.io_rptCnt), 4);
      chk("s3_busy",  32'(bus.io_logicBusy), 1);
      // abort together with logicEnd in RUN
      bus.io_abort    = 1'b1;
      bus.io_logicEnd = 1'b1;
      tick();
      bus.io_abort    = 1'b0;
      bus.io_logicEnd = 1'b0;
      tick();
      chk("s3_aborted", 32'(ab_now), 1);
      chk("s3_nodone",  n_done, 0);
      chk("s3_abbusy",  32'(bus.io_logicBusy), 0);
      chk("s3_abcnt",   32'(bus.io_rptCnt), 4);

      // abort in GAP exactly on the rptEn cycle
      clr_counts();
      trigger(4'd3, 8'd4, 1'b0);
      tick();
      pulse_end();
      repeat (3) tick();
      bus.io_abort = 1'b1;
      tick();
      chk("s4_en_supp", 32'(en_now), 0);
      bus.io_abort = 1'b0;
      tick();
      chk("s4_aborted", 32'(ab_now), 1);
      chk("s4_busy",    32'(bus.io_logicBusy), 0);
      pulse_end();
      tick();
      chk("s4_idle_end", n_en + n_done, 0);
      chk("s4_cnt",      32'(bus.io_rptCnt), 1);
      chk("s4_nab",      n_ab, 1);

      // re-trigger with new config mid-sequence is ignored
      clr_counts();
      trigger(4'd1, 8'd3, 1'b0);
      tick();
      pulse_end();
      tick();
      bus.io_rptNo       = 4'd5;
      bus.io_rptTime     = 8'd7;
      bus.io_mainTrigger = 1'b1;
      tick();
      bus.io_mainTrigger = 1'b0;
      chk("s5_cnt_kept", 32'(bus.io_rptCnt), 1);
      chk("s5_busy",     32'(bus.io_logicBusy), 1);
      wait_en("s5_en", 3);
      tick();
      pulse_end();
      tick();
      chk("s5_done", 32'(done_now), 1);
      chk("s5_cnt",  32'(bus.io_rptCnt), 2);
      chk("s5_nen",  n_en, 1);

      // asynchronous reset in GAP, then trigger in the first cycle after release
      clr_counts();
      trigger(4'd2, 8'd6, 1'b0);
      tick();
      pulse_end();
      repeat (2) tick();
      #2 io_rst = 1'b1;
      #1;
      chk("s6_busy",  32'(bus.io_logicBusy), 0);
      chk("s6_cnt",   32'(bus.io_rptCnt), 0);
      chk("s6_en",    32'(bus.io_rptEn), 0);
      repeat (2) tick();
      chk("s6_nopulse", n_en + n_done + n_ab, 0);
      io_rst = 1'b0;
      trigger(4'd1, 8'd2, 1'b0);
      chk("s6_restart", 32'(bus.io_logicBusy), 1);
      tick();
      pulse_end();
      wait_en("s6_en", 2);
      tick();
      pulse_end();
      tick();
      chk("s6_done", 32'(done_now), 1);
      chk("s6_nab",  n_ab, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/logic_repeat_seq.md
LOGIC_REPEAT_SEQ -- requirements
Module: logic_repeat_seq

Interface
REQ-001 Parameter CNT_W, default 16, width of the repeat count and pass counter.
REQ-002 Parameter TIME_W, default 24, width of the inter-pass gap, in clock cycles.
REQ-003 io_clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 io_rst  input  1  reset; asynchronous, active-high.
REQ-005 io_mainTrigger  input  1  start pulse; latches configuration and begins pass 0.
REQ-006 io_rptNo  input  CNT_W  number of additional passes after pass 0.
REQ-007 io_rptTime  input  TIME_W  gap between the end of one pass and the next io_rptEn.
REQ-008 io_infinite  input  1  repeat indefinitely; io_rptNo is ignored.
REQ-009 io_abort  input  1  terminate the sequence immediately.
REQ-010 io_logicEnd  input  1  one-cycle pulse from the logic engine: current pass finished.
REQ-011 io_rptEn  output  1  one-cycle pulse requesting the engine to start the next pass.
REQ-012 io_logicBusy  output  1  registered; sequence in progress.
REQ-013 io_rptCnt  output  CNT_W  completed passes in the current sequence.
REQ-014 io_done  output  1  one-cycle pulse; sequence completed normally.
REQ-015 io_aborted  output  1  one-cycle pulse; sequence terminated by io_abort.

Function
REQ-016 FSM states SHALL be IDLE, RUN (waiting for io_logicEnd) and GAP (timing the interval).
REQ-017 In IDLE, io_mainTrigger SHALL latch io_rptNo, io_rptTime and io_infinite, clear io_rptCnt and the gap counter, enter RUN, and raise io_logicBusy on the next cycle.
REQ-018 io_mainTrigger outside IDLE SHALL be ignored; latched configuration stays unchanged for the whole sequence.
REQ-019 In RUN, io_logicEnd SHALL increment io_rptCnt, then:
- if io_infinite is latched, or the pre-increment io_rptCnt is below the latched rptNo, enter GAP with the gap counter at 0;
- otherwise enter IDLE, pulse io_done for one cycle and drop io_logicBusy, all on the next cycle.
REQ-020 In GAP, the gap counter SHALL increment each cycle; io_rptEn SHALL be combinationally high when the counter equals latched rptTime-1, and the FSM SHALL enter RUN on the following edge.
REQ-021 Latched rptTime of 0 SHALL be treated as 1.
REQ-022 Timing: io_logicEnd at cycle t SHALL produce io_rptEn at cycle t+max(rptTime,1).
REQ-023 Latched rptNo of 0 with io_infinite low SHALL give a single pass: io_done one cycle after the first io_logicEnd, and io_rptEn never asserted.
REQ-024 io_logicEnd in IDLE or GAP SHALL be ignored.
REQ-025 io_abort in RUN or GAP SHALL force IDLE on the next edge, pulse io_aborted, drop io_logicBusy, and suppress io_rptEn in that cycle; io_abort in IDLE SHALL be a no-op.
REQ-026 io_abort SHALL win over a same-cycle io_logicEnd or io_mainTrigger.
REQ-027 io_rptCnt SHALL wrap modulo 2^CNT_W in infinite mode and hold its final value in IDLE until the next trigger.
REQ-028 Comparisons SHALL be unsigned at full parameter width, with no truncation of rptTime-1.

Reset
REQ-029 Asserting io_rst SHALL asynchronously force IDLE and clear io_logicBusy, io_rptCnt, the gap counter and latched configuration; io_rptEn, io_done and io_aborted are 0.
REQ-030 Reset mid-sequence SHALL discard the sequence with no io_done or io_aborted pulse.
REQ-031 The first trigger SHALL be accepted in the first cycle after io_rst deasserts.

Structure
REQ-032 Package logic_repeat_pkg SHALL hold the FSM state typedef and the default CNT_W/TIME_W constants.
REQ-033 The gap timer (load, count, terminal-count flag) SHALL be the sub-module rpt_gap_timer, parameterised by TIME_W; all other logic is flat.

Verification
REQ-034 rptNo=2, rptTime=5, infinite=0; trigger, then io_logicEnd 3 cycles after each io_rptEn -> io_rptEn exactly twice, each 5 cycles after io_logicEnd; io_done after the 3rd io_logicEnd; io_rptCnt=3; busy low.
REQ-035 rptNo=0, rptTime=0 -> one io_logicEnd gives io_done next cycle, no io_rptEn; then rptNo=1, rptTime=0 -> io_rptEn one cycle after the first io_logicEnd.
REQ-036 infinite=1, CNT_W=4, rptTime=1; 20 passes -> io_rptEn after every pass, io_rptCnt wraps 15->0, no io_done.
REQ-037 Abort in GAP on the same cycle io_rptEn would assert -> no io_rptEn, io_aborted pulse, IDLE next cycle; io_abort and io_logicEnd together in RUN -> io_aborted only.
REQ-038 Change io_rptNo and io_rptTime and re-pulse io_mainTrigger mid-sequence -> original count and gap still used, no restart.
REQ-039 io_rst asserted in GAP -> outputs clear asynchronously, no pulses; a trigger in the first cycle after release starts a new sequence.
